// File: rtl/mem_arbiter.sv
// Serialises an instruction port (A, read-only) and a data port (B, read/write)
// onto one physical memory port. Fixed priority B over A, optional joint response release.
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int JOINT_RESP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_read,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  output logic                    a_resp,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic                    b_read,
  input  logic                    b_write,
  input  logic [DATA_WIDTH/8-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_resp,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [DATA_WIDTH/8-1:0] pmem_wmask,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata,
  input  logic                    pmem_resp,
  output logic [1:0]              dbg_state
);

  localparam int MW = DATA_WIDTH / 8;

  // Handshake: requests are levels held until the matching resp; resp is a
  // registered completion flag, and pmem_resp is a one-cycle pulse from memory.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  done_a_q, done_a_d;
  logic                  done_b_q, done_b_d;
  logic                  pmem_read_q, pmem_read_d;
  logic                  pmem_write_q, pmem_write_d;
  logic [MW-1:0]         pmem_wmask_q, pmem_wmask_d;
  logic [ADDR_WIDTH-1:0] pmem_address_q, pmem_address_d;
  logic [DATA_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  b_req;
  logic                  release_now;

  always_comb begin
    state_d        = state_q;
    done_a_d       = done_a_q;
    done_b_d       = done_b_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_wmask_d   = pmem_wmask_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    a_rdata_d      = a_rdata_q;
    b_rdata_d      = b_rdata_q;
    b_req          = b_read | b_write;
    // Release mirrors the datapath advance condition; only meaningful when responses are held.
    release_now    = (JOINT_RESP != 0) &&
                     ((done_a_q & (done_b_q | ~b_req)) | (done_b_q & ~a_read));

    // Without joint release every done flag lives for exactly one cycle.
    if (JOINT_RESP == 0) begin
      done_a_d = 1'b0;
      done_b_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (release_now) begin
          done_a_d = 1'b0;
          done_b_d = 1'b0;
        end else if (b_req && !done_b_q) begin
          pmem_read_d    = b_read;
          pmem_write_d   = b_write;
          pmem_wmask_d   = b_write ? b_wmask : {MW{1'b1}};
          pmem_address_d = b_address;
          pmem_wdata_d   = b_wdata;
          state_d        = BUSY_B;
        end else if (a_read && !done_a_q) begin
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_wmask_d   = {MW{1'b1}};
          pmem_address_d = a_address;
          pmem_wdata_d   = '0;
          state_d        = BUSY_A;
        end
      end
      BUSY_A: begin
        if (pmem_resp) begin
          a_rdata_d    = pmem_rdata;
          done_a_d     = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = IDLE;
        end
      end
      BUSY_B: begin
        if (pmem_resp) begin
          if (pmem_read_q) b_rdata_d = pmem_rdata;
          done_b_d     = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      done_a_q       <= 1'b0;
      done_b_q       <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_wmask_q   <= '0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      a_rdata_q      <= '0;
      b_rdata_q      <= '0;
    end else begin
      state_q        <= state_d;
      done_a_q       <= done_a_d;
      done_b_q       <= done_b_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_wmask_q   <= pmem_wmask_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      a_rdata_q      <= a_rdata_d;
      b_rdata_q      <= b_rdata_d;
    end
  end

  assign a_resp       = done_a_q;
  assign b_resp       = done_b_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_wmask   = pmem_wmask_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a joint-response instance (u1) and a
// pulse-response instance (u0) share stimulus; read data checked through queues.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_read;
  logic [15:0] a_address;
  logic        b_read;
  logic        b_write;
  logic [1:0]  b_wmask;
  logic [15:0] b_address;
  logic [15:0] b_wdata;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  logic        u1_a_resp, u1_b_resp, u1_pmem_read, u1_pmem_write;
  logic [15:0] u1_a_rdata, u1_b_rdata, u1_pmem_address, u1_pmem_wdata;
  logic [1:0]  u1_pmem_wmask, u1_dbg_state;
  logic        u0_a_resp, u0_b_resp, u0_pmem_read, u0_pmem_write;
  logic [15:0] u0_a_rdata, u0_b_rdata, u0_pmem_address, u0_pmem_wdata;
  logic [1:0]  u0_pmem_wmask, u0_dbg_state;

  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  logic [15:0] last_b;
  int          n_assert = 0;
  int          n_fail   = 0;

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .JOINT_RESP(1)) u1 (
    .clk(clk), .rst(rst),
    .a_read(a_read), .a_address(a_address), .a_resp(u1_a_resp), .a_rdata(u1_a_rdata),
    .b_read(b_read), .b_write(b_write), .b_wmask(b_wmask), .b_address(b_address),
    .b_wdata(b_wdata), .b_resp(u1_b_resp), .b_rdata(u1_b_rdata),
    .pmem_read(u1_pmem_read), .pmem_write(u1_pmem_write), .pmem_wmask(u1_pmem_wmask),
    .pmem_address(u1_pmem_address), .pmem_wdata(u1_pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .dbg_state(u1_dbg_state)
  );

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .JOINT_RESP(0)) u0 (
    .clk(clk), .rst(rst),
    .a_read(a_read), .a_address(a_address), .a_resp(u0_a_resp), .a_rdata(u0_a_rdata),
    .b_read(b_read), .b_write(b_write), .b_wmask(b_wmask), .b_address(b_address),
    .b_wdata(b_wdata), .b_resp(u0_b_resp), .b_rdata(u0_b_rdata),
    .pmem_read(u0_pmem_read), .pmem_write(u0_pmem_write), .pmem_wmask(u0_pmem_wmask),
    .pmem_address(u0_pmem_address), .pmem_wdata(u0_pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .dbg_state(u0_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [15:0] addr);
    return (addr == 16'h0010) ? 16'h1234 : (addr ^ 16'hA5C3);
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_a(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_a_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
    end else begin
      e = exp_a_q.pop_front();
      chk(tag, {16'h0, obs}, {16'h0, e});
    end
  endtask

  task automatic pop_b(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_b_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
    end else begin
      e = exp_b_q.pop_front();
      last_b = e;
      chk(tag, {16'h0, obs}, {16'h0, e});
    end
  endtask

  // Memory model driver: answers one cycle with the word stored at addr.
  task automatic respond(input logic [15:0] addr);
    pmem_rdata = mem_model(addr);
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = 16'h0;
  endtask

  initial begin
    rst = 1'b1; a_read = 1'b0; a_address = '0; b_read = 1'b0; b_write = 1'b0;
    b_wmask = '0; b_address = '0; b_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    last_b = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_a_resp", u1_a_resp, 0);
    chk("rst_b_resp", u1_b_resp, 0);
    chk("rst_pmem_read", u1_pmem_read, 0);
    chk("rst_pmem_addr", u1_pmem_address, 0);
    chk("rst_state", u1_dbg_state, 0);

    // 1: single fetch
    a_read = 1'b1; a_address = 16'h0010;
    exp_a_q.push_back(mem_model(16'h0010));
    tick();
    chk("s1_pmem_read", u1_pmem_read, 1);
    chk("s1_pmem_addr", u1_pmem_address, 16'h0010);
    chk("s1_pmem_wmask", u1_pmem_wmask, 2'b11);
    chk("s1_pmem_wdata", u1_pmem_wdata, 0);
    chk("s1_state", u1_dbg_state, 1);
    tick(2);
    chk("s1_a_resp_wait", u1_a_resp, 0);
    respond(u1_pmem_address);
    chk("s1_a_resp", u1_a_resp, 1);
    pop_a("s1_a_rdata", u1_a_rdata);
    chk("s1_strobe_low", u1_pmem_read, 0);
    tick();
    chk("s1_a_resp_drop", u1_a_resp, 0);
    a_read = 1'b0;
    tick();
    chk("s1_no_regrant", u1_pmem_read, 0);

    // 2: simultaneous requests, B first, joint release
    a_read = 1'b1; a_address = 16'h0020; b_read = 1'b1; b_address = 16'h0100;
    exp_a_q.push_back(mem_model(16'h0020));
    exp_b_q.push_back(mem_model(16'h0100));
    tick();
    chk("s2_first_addr", u1_pmem_address, 16'h0100);
    chk("s2_first_state", u1_dbg_state, 2);
    respond(u1_pmem_address);
    chk("s2_b_resp", u1_b_resp, 1);
    chk("s2_a_resp_early", u1_a_resp, 0);
    pop_b("s2_b_rdata", u1_b_rdata);
    tick();
    chk("s2_second_addr", u1_pmem_address, 16'h0020);
    chk("s2_second_read", u1_pmem_read, 1);
    chk("s2_b_held", u1_b_resp, 1);
    respond(u1_pmem_address);
    chk("s2_joint_a", u1_a_resp, 1);
    chk("s2_joint_b", u1_b_resp, 1);
    pop_a("s2_a_rdata", u1_a_rdata);
    chk("s2_b_rdata_stable", u1_b_rdata, last_b);
    tick();
    chk("s2_a_drop", u1_a_resp, 0);
    chk("s2_b_drop", u1_b_resp, 0);
    a_read = 1'b0; b_read = 1'b0;

    // 3: byte-masked store
    b_write = 1'b1; b_address = 16'h0200; b_wdata = 16'hBEEF; b_wmask = 2'b01;
    tick();
    chk("s3_write", u1_pmem_write, 1);
    chk("s3_read", u1_pmem_read, 0);
    chk("s3_wdata", u1_pmem_wdata, 16'hBEEF);
    chk("s3_wmask", u1_pmem_wmask, 2'b01);
    chk("s3_addr", u1_pmem_address, 16'h0200);
    respond(u1_pmem_address);
    chk("s3_b_resp", u1_b_resp, 1);
    chk("s3_b_rdata_kept", u1_b_rdata, last_b);
    chk("s3_write_low", u1_pmem_write, 0);
    tick();
    chk("s3_b_drop", u1_b_resp, 0);
    b_write = 1'b0; b_wmask = 2'b00;

    // 4: address change while busy
    a_read = 1'b1; a_address = 16'h0030;
    exp_a_q.push_back(mem_model(16'h0030));
    tick();
    a_address = 16'h0040;
    tick();
    chk("s4_addr_hold1", u1_pmem_address, 16'h0030);
    tick();
    chk("s4_addr_hold2", u1_pmem_address, 16'h0030);
    respond(u1_pmem_address);
    chk("s4_a_resp", u1_a_resp, 1);
    pop_a("s4_a_rdata", u1_a_rdata);
    tick();
    a_read = 1'b0;

    // 5: reset mid-access, then stray response
    b_read = 1'b1; b_address = 16'h0300;
    tick();
    chk("s5_busy", u1_pmem_read, 1);
    rst = 1'b1; b_read = 1'b0;
    tick();
    rst = 1'b0;
    chk("s5_read0", u1_pmem_read, 0);
    chk("s5_addr0", u1_pmem_address, 0);
    chk("s5_b_rdata0", u1_b_rdata, 0);
    chk("s5_a_rdata0", u1_a_rdata, 0);
    chk("s5_state0", u1_dbg_state, 0);
    respond(16'h0300);
    chk("s5_stray_a", u1_a_resp, 0);
    chk("s5_stray_b", u1_b_resp, 0);
    chk("s5_stray_u0_b", u0_b_resp, 0);
    chk("s5_stray_rdata", u1_b_rdata, 0);

    // 6: pulse-response instance, simultaneous requests
    a_read = 1'b1; a_address = 16'h0020; b_read = 1'b1; b_address = 16'h0100;
    exp_a_q.push_back(mem_model(16'h0020));
    exp_b_q.push_back(mem_model(16'h0100));
    tick();
    chk("s6_first_addr", u0_pmem_address, 16'h0100);
    respond(u0_pmem_address);
    chk("s6_b_pulse", u0_b_resp, 1);
    chk("s6_a_quiet", u0_a_resp, 0);
    pop_b("s6_b_rdata", u0_b_rdata);
    b_read = 1'b0;
    tick();
    chk("s6_b_cleared", u0_b_resp, 0);
    chk("s6_second_addr", u0_pmem_address, 16'h0020);
    respond(u0_pmem_address);
    chk("s6_a_pulse", u0_a_resp, 1);
    chk("s6_b_off", u0_b_resp, 0);
    pop_a("s6_a_rdata", u0_a_rdata);
    a_read = 1'b0;
    tick();
    chk("s6_a_cleared", u0_a_resp, 0);
    chk("s6_idle", u0_pmem_read, 0);
    chk("s6_queues_empty", exp_a_q.size() + exp_b_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
